sram_rr_arbiter: RTL and testbench
==================================

Name: sram_rr_arbiter

Overview:
- Shares the single-port synchronous SRAM (`ram`: clk, write, data_in, addr, data_out) between two requesters.
- Uses round-robin arbitration with a valid/ready request handshake per requester.
- Read data is returned to the owning requester with a one-cycle response strobe.
- Sits between the two client blocks and the `ram` instance; it is the only driver of the RAM's write, addr and data_in.

Parameters:
- ADDR_WIDTH, 8, SRAM address width.
- DATA_WIDTH, 8, SRAM data width.
- DEPTH, 256, SRAM words. Informational only; must equal 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has a request.
- req0_write  input  1  1 = write, 0 = read.
- req0_addr  input  ADDR_WIDTH  request address.
- req0_wdata  input  DATA_WIDTH  write data.
- req0_ready  output  1  request accepted this cycle.
- rsp0_valid  output  1  read data for requester 0 valid this cycle.
- rsp0_rdata  output  DATA_WIDTH  read data.
- req1_valid, req1_write, req1_addr, req1_wdata, req1_ready, rsp1_valid, rsp1_rdata: same as requester 0, for requester 1.
- ram_write  output  1  to ram write.
- ram_addr  output  ADDR_WIDTH  to ram addr.
- ram_wdata  output  DATA_WIDTH  to ram data_in.
- ram_rdata  input  DATA_WIDTH  from ram data_out.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- RAM model (decided): write occurs at the rising edge when write=1. A read registers data_out at the rising edge when write=0, so data is visible in the following cycle (1-cycle read latency).
- Arbitration:
  - Combinational each cycle.
  - If only one req_valid is high, that requester is granted.
  - If both are high, the requester indicated by the priority pointer `prio` is granted.
  - At most one req_ready is high per cycle.
  - req_ready depends only on the req_valid inputs and `prio`, never on addr/data.
- Pointer update: on any accepted request (valid & ready), `prio` becomes the other requester. With no acceptance, `prio` holds.
- RAM drive when granted: ram_write = granted req_write; ram_addr / ram_wdata = granted addr / wdata.
- RAM drive when idle: ram_write = 0; ram_addr and ram_wdata hold their last values (registered mux select). No spurious writes.
- Read tracking:
  - Registered `rd_pend` (1b) and `rd_owner` (1b) are set when a read is accepted.
  - In the next cycle the owner's rsp_valid = 1 for exactly one cycle, and rsp_rdata = ram_rdata.
  - The non-owner's rsp_valid = 0.
  - rsp_rdata may show ram_rdata unconditionally; it is qualified by rsp_valid.
- Throughput: one accepted request per cycle. Back-to-back reads from alternating requesters give one response per cycle.
- Writes produce no response.
- Read-after-write to the same address in consecutive cycles returns the new data (RAM ordering).
- Requester rules:
  - A requester must hold valid/write/addr/wdata stable until ready.
  - The arbiter never drops a request that has not been accepted.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1…; max wait is 1 cycle.
- Reset values: prio = 0 (requester 0 first), rd_pend = 0, rd_owner = 0, rsp0/1_valid = 0, ram_write = 0, ram_addr = 0, ram_wdata = 0, req0/1_ready = 0 while reset is high.
- Reset mid-operation: a read accepted in the cycle before reset asserts has its response suppressed (rsp_valid forced 0 during reset). No RAM write is issued during any reset cycle.
- No internal state machine beyond `prio` and the read pipeline register. The states are IDLE (rd_pend=0) and RESP (rd_pend=1). RESP lasts one cycle and overlaps with a new grant.

Decomposition:
- Shared include `sram_defs.vh`: ADDR_WIDTH/DATA_WIDTH/DEPTH defaults, RD_LATENCY = 1, requester-ID localparams REQ0 = 0, REQ1 = 1.
- Sub-module `rr_arb2`: 2-input round-robin arbiter (clk, reset, valid[1:0], accept → grant[1:0], prio register).
- Top `sram_rr_arbiter`: datapath mux, read tracking, RAM outputs.

Test Plan:
- Single writes then reads: r0 writes 0xAA @0, r1 writes 0x55 @1; then r0 reads @1 → rsp0_valid one cycle later with 0x55. Then r1 reads @0 → rsp1_valid with 0xAA; rsp0_valid stays 0.
- Contention: both valid reads every cycle (r0 @0, r1 @1) after reset → grants 0,1,0,1. Responses alternate rsp0 = 0xAA, rsp1 = 0x55, each 1 cycle after its grant.
- Read-after-write hazard: r0 writes 0x2A @1, r1 reads @1 in the next cycle → rsp1_rdata = 0x2A.
- Mixed contention: r0 write 0x11 @5 and r1 read @5 simultaneous, with prio = 1 → r1 granted first and returns the old value. Then r0 is written. A later read @5 returns 0x11.
- Reset mid-read: r0 read accepted, reset asserted the next cycle → rsp0_valid = 0 and ram_write = 0 throughout reset. After release, prio = 0 and both-valid grants r0 first.
- Idle: no valid for 10 cycles → ram_write = 0, both readies 0, both rsp_valid 0, RAM contents unchanged on a readback.

Source files
------------

// File: rtl/sram_rr_arbiter_pkg.sv
// Shared definitions for the two-requester SRAM arbiter: default geometry,
// read latency of the attached RAM and requester identifiers.
package sram_rr_arbiter_pkg;

   localparam int ADDR_WIDTH_DEF = 8;
   localparam int DATA_WIDTH_DEF = 8;
   localparam int DEPTH_DEF      = 256;

   // Cycles from an accepted read to valid ram_rdata.
   localparam int RD_LATENCY = 1;

   // Requester identifiers, also used as the encoding of prio and rd_owner.
   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

   // The requester that is not 'id'.
   function automatic logic other_req(input logic id);
      return ~id;
   endfunction

   // Identifier of the requester named by a one-hot grant vector.
   function automatic logic grant_id(input logic [1:0] grant);
      return grant[1] ? REQ1 : REQ0;
   endfunction

endpackage : sram_rr_arbiter_pkg

// File: rtl/sram_rr_arbiter_rr_arb2.sv
// Two-input round-robin arbiter. The grant is purely combinational from
// the valid inputs and the priority pointer; the pointer moves to the other
// requester whenever a grant is taken.
module rr_arb2
   import sram_rr_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] valid,
   input  logic       accept,
   output logic [1:0] grant
);

   logic prio_q;
   logic prio_d;

   // Grant selection: a lone requester wins, contention goes to prio.
   always_comb begin
      grant = 2'b00;
      if (!reset) begin
         case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (prio_q == REQ1) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
         endcase
      end
   end

   // Next pointer: after an acceptance the other requester gets priority.
   always_comb begin
      prio_d = prio_q;
      if (accept) begin
         prio_d = other_req(grant_id(grant));
      end
   end

   // Pointer register; requester 0 has priority out of reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         prio_q <= REQ0;
      end else begin
         prio_q <= prio_d;
      end
   end

endmodule : rr_arb2

// File: rtl/sram_rr_arbiter.sv
// Shares one single-port synchronous SRAM between two valid/ready
// requesters. Accepted requests are driven straight onto the RAM port in
// the same cycle; read data comes back one cycle later on the owner's
// response strobe. When idle the RAM address/data hold their last values
// and no write is ever issued.
module sram_rr_arbiter
   import sram_rr_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int DEPTH      = DEPTH_DEF
) (
   input  logic                  clk,
   input  logic                  reset,

   input  logic                  req0_valid,
   input  logic                  req0_write,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [DATA_WIDTH-1:0] req0_wdata,
   output logic                  req0_ready,
   output logic                  rsp0_valid,
   output logic [DATA_WIDTH-1:0] rsp0_rdata,

   input  logic                  req1_valid,
   input  logic                  req1_write,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [DATA_WIDTH-1:0] req1_wdata,
   output logic                  req1_ready,
   output logic                  rsp1_valid,
   output logic [DATA_WIDTH-1:0] rsp1_rdata,

   output logic                  ram_write,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_rdata
);

   // DEPTH only documents the RAM size; it has to agree with the address width.
   if (DEPTH != (2 ** ADDR_WIDTH)) begin : g_depth_check
      $error("sram_rr_arbiter: DEPTH must equal 2**ADDR_WIDTH");
   end

   logic [1:0]            valid;
   logic [1:0]            grant;
   logic                  accept;

   logic                  sel_id;
   logic                  sel_write;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;

   logic [ADDR_WIDTH-1:0] addr_q;
   logic [ADDR_WIDTH-1:0] addr_d;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] wdata_d;
   logic                  rd_pend_q;
   logic                  rd_pend_d;
   logic                  rd_owner_q;
   logic                  rd_owner_d;

   rr_arb2 u_arb (
      .clk    (clk),
      .reset  (reset),
      .valid  (valid),
      .accept (accept),
      .grant  (grant)
   );

   // Handshake: ready is the grant itself, so it never looks at addr/data.
   always_comb begin
      valid      = {req1_valid, req0_valid};
      accept     = |(valid & grant);
      req0_ready = grant[0];
      req1_ready = grant[1];
   end

   // Request mux: pick the granted requester's command fields.
   always_comb begin
      sel_id    = grant_id(grant);
      sel_write = (sel_id == REQ1) ? req1_write : req0_write;
      sel_addr  = (sel_id == REQ1) ? req1_addr  : req0_addr;
      sel_wdata = (sel_id == REQ1) ? req1_wdata : req0_wdata;
   end

   // Held RAM address/data: capture whatever was last put on the port.
   always_comb begin
      addr_d  = addr_q;
      wdata_d = wdata_q;
      if (accept) begin
         addr_d  = sel_addr;
         wdata_d = sel_wdata;
      end
   end

   // RAM port drive: live command when granted, held values when idle.
   always_comb begin
      ram_write = 1'b0;
      ram_addr  = addr_q;
      ram_wdata = wdata_q;
      if (reset) begin
         ram_addr  = '0;
         ram_wdata = '0;
      end else if (accept) begin
         ram_write = sel_write;
         ram_addr  = sel_addr;
         ram_wdata = sel_wdata;
      end
   end

   // Read tracking: remember that a read went out and who issued it.
   always_comb begin
      rd_pend_d  = accept & ~sel_write;
      rd_owner_d = rd_owner_q;
      if (accept) begin
         rd_owner_d = sel_id;
      end
   end

   // Response strobe for the owner of last cycle's read; squashed in reset.
   always_comb begin
      rsp0_valid = ~reset & rd_pend_q & (rd_owner_q == REQ0);
      rsp1_valid = ~reset & rd_pend_q & (rd_owner_q == REQ1);
      rsp0_rdata = ram_rdata;
      rsp1_rdata = ram_rdata;
   end

   // State registers for the held RAM port values and the read pipeline.
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q     <= '0;
         wdata_q    <= '0;
         rd_pend_q  <= 1'b0;
         rd_owner_q <= REQ0;
      end else begin
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rd_pend_q  <= rd_pend_d;
         rd_owner_q <= rd_owner_d;
      end
   end

endmodule : sram_rr_arbiter

// File: tb/tb_sram_rr_arbiter.sv
// Self-checking bench for sram_rr_arbiter with a behavioural RAM and a
// transaction-level reference model (priority flag, shadow memory, one
// outstanding read) checked against the DUT every cycle.
module tb_sram_rr_arbiter;

   localparam int AW = 8;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          req0_valid, req0_write, req0_ready, rsp0_valid;
   logic [AW-1:0] req0_addr;
   logic [DW-1:0] req0_wdata, rsp0_rdata;
   logic          req1_valid, req1_write, req1_ready, rsp1_valid;
   logic [AW-1:0] req1_addr;
   logic [DW-1:0] req1_wdata, rsp1_rdata;
   logic          ram_write;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;

   int checks = 0;
   int errors = 0;

   // reference model state
   int            m_prio;
   bit            m_pend;
   int            m_owner;
   logic [DW-1:0] m_rdata;
   logic [AW-1:0] m_laddr;
   logic [DW-1:0] m_lwdata;
   logic [DW-1:0] shadow [256];
   int            last_g;

   // behavioural single-port RAM
   logic [DW-1:0] mem [256];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_write) mem[ram_addr] <= ram_wdata;
      else           ram_rdata     <= mem[ram_addr];
   end

   sram_rr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(256)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
      .req0_wdata(req0_wdata), .req0_ready(req0_ready), .rsp0_valid(rsp0_valid),
      .rsp0_rdata(rsp0_rdata),
      .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
      .req1_wdata(req1_wdata), .req1_ready(req1_ready), .rsp1_valid(rsp1_valid),
      .rsp1_rdata(rsp1_rdata),
      .ram_write(ram_write), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: check every DUT output against the model at the negedge,
   // advance the model to the next rising edge, return just after it.
   task automatic step();
      int            g;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wdata;
      logic          e_write;
      logic          g_write;
      logic [AW-1:0] g_addr;
      logic [DW-1:0] g_wdata;
      @(negedge clk);
      if (reset)                         g = -1;
      else if (req0_valid && req1_valid) g = m_prio;
      else if (req0_valid)               g = 0;
      else if (req1_valid)               g = 1;
      else                               g = -1;
      g_write = (g == 1) ? req1_write : req0_write;
      g_addr  = (g == 1) ? req1_addr  : req0_addr;
      g_wdata = (g == 1) ? req1_wdata : req0_wdata;
      e_write = (g >= 0) && g_write;
      e_addr  = reset ? '0 : ((g >= 0) ? g_addr  : m_laddr);
      e_wdata = reset ? '0 : ((g >= 0) ? g_wdata : m_lwdata);

      chk("req0_ready", 32'(req0_ready), 32'(g == 0));
      chk("req1_ready", 32'(req1_ready), 32'(g == 1));
      chk("ram_write",  32'(ram_write),  32'(e_write));
      chk("ram_addr",   32'(ram_addr),   32'(e_addr));
      chk("ram_wdata",  32'(ram_wdata),  32'(e_wdata));
      chk("rsp0_valid", 32'(rsp0_valid), 32'(!reset && m_pend && m_owner == 0));
      chk("rsp1_valid", 32'(rsp1_valid), 32'(!reset && m_pend && m_owner == 1));
      if (!reset && m_pend) begin
         if (m_owner == 0) chk("rsp0_rdata", 32'(rsp0_rdata), 32'(m_rdata));
         else              chk("rsp1_rdata", 32'(rsp1_rdata), 32'(m_rdata));
      end

      last_g = g;
      if (reset) begin
         m_prio = 0; m_pend = 0; m_owner = 0; m_laddr = '0; m_lwdata = '0;
      end else if (g >= 0) begin
         m_prio   = 1 - g;
         m_laddr  = g_addr;
         m_lwdata = g_wdata;
         m_owner  = g;
         m_pend   = !g_write;
         if (g_write) shadow[g_addr] = g_wdata;
         else         m_rdata = shadow[g_addr];
      end else begin
         m_pend = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set0(input logic v, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req0_valid = v; req0_write = w; req0_addr = a; req0_wdata = d;
   endtask

   task automatic set1(input logic v, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req1_valid = v; req1_write = w; req1_addr = a; req1_wdata = d;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i] = '0;
         shadow[i] = '0;
      end
      ram_rdata = '0;
      m_prio = 0; m_pend = 0; m_owner = 0; m_rdata = '0; m_laddr = '0; m_lwdata = '0;
      last_g = -1;
      reset = 1'b1;
      set0(1'b0, 1'b0, 8'h00, 8'h00);
      set1(1'b0, 1'b0, 8'h00, 8'h00);
      #1;
      chk("lit_reset_ready0", 32'(req0_ready), 32'(0));
      chk("lit_reset_ramaddr", 32'(ram_addr), 32'(0));
      step(); step();
      reset = 1'b0;
      step();

      // single writes then reads
      set0(1'b1, 1'b1, 8'h00, 8'hAA); step();
      set0(1'b0, 1'b0, 8'h00, 8'h00);
      set1(1'b1, 1'b1, 8'h01, 8'h55); step();
      set1(1'b0, 1'b0, 8'h00, 8'h00);
      set0(1'b1, 1'b0, 8'h01, 8'h00); step();
      set0(1'b0, 1'b0, 8'h00, 8'h00);
      chk("lit_rsp0_valid", 32'(rsp0_valid), 32'(1));
      chk("lit_rsp0_55", 32'(rsp0_rdata), 32'(8'h55));
      set1(1'b1, 1'b0, 8'h00, 8'h00); step();
      set1(1'b0, 1'b0, 8'h00, 8'h00);
      chk("lit_rsp1_AA", 32'(rsp1_rdata), 32'(8'hAA));
      chk("lit_rsp0_idle", 32'(rsp0_valid), 32'(0));

      // contention: both read continuously, grants alternate starting with 0
      set0(1'b1, 1'b0, 8'h00, 8'h00);
      set1(1'b1, 1'b0, 8'h01, 8'h00);
      for (int k = 0; k < 4; k++) begin
         step();
         chk("lit_alt_grant", 32'(last_g), 32'(k % 2));
         if (k % 2 == 0) chk("lit_alt_rsp0", 32'(rsp0_rdata), 32'(8'hAA));
         else            chk("lit_alt_rsp1", 32'(rsp1_rdata), 32'(8'h55));
      end
      set0(1'b0, 1'b0, 8'h00, 8'h00);
      set1(1'b0, 1'b0, 8'h00, 8'h00);

      // read-after-write in consecutive cycles
      set0(1'b1, 1'b1, 8'h01, 8'h2A); step();
      set0(1'b0, 1'b0, 8'h00, 8'h00);
      set1(1'b1, 1'b0, 8'h01, 8'h00); step();
      set1(1'b0, 1'b0, 8'h00, 8'h00);
      chk("lit_raw_2A", 32'(rsp1_rdata), 32'(8'h2A));

      // mixed contention with prio on requester 1
      set0(1'b1, 1'b0, 8'h03, 8'h00); step();   // grant 0 -> prio 1
      set0(1'b1, 1'b1, 8'h05, 8'h11);
      set1(1'b1, 1'b0, 8'h05, 8'h00); step();
      chk("lit_mix_grant1", 32'(last_g), 32'(1));
      chk("lit_mix_old", 32'(rsp1_rdata), 32'(8'h00));
      set1(1'b0, 1'b0, 8'h00, 8'h00); step();   // held write from requester 0
      chk("lit_mix_grant0", 32'(last_g), 32'(0));
      set0(1'b0, 1'b0, 8'h00, 8'h00);
      set1(1'b1, 1'b0, 8'h05, 8'h00); step();
      set1(1'b0, 1'b0, 8'h00, 8'h00);
      chk("lit_mix_new", 32'(rsp1_rdata), 32'(8'h11));

      // reset in the cycle after a read is accepted
      set0(1'b1, 1'b0, 8'h00, 8'h00); step();
      reset = 1'b1;
      set0(1'b1, 1'b1, 8'h07, 8'hEE);
      set1(1'b1, 1'b1, 8'h07, 8'hDD);
      #1;
      chk("lit_rst_rsp0", 32'(rsp0_valid), 32'(0));
      chk("lit_rst_write", 32'(ram_write), 32'(0));
      step(); step();
      reset = 1'b0;
      set0(1'b1, 1'b0, 8'h00, 8'h00);
      set1(1'b1, 1'b0, 8'h01, 8'h00); step();
      chk("lit_post_rst_grant", 32'(last_g), 32'(0));
      set0(1'b0, 1'b0, 8'h00, 8'h00); step();   // drain requester 1
      set1(1'b0, 1'b0, 8'h00, 8'h00);

      // idle, then readback of an earlier write
      for (int k = 0; k < 10; k++) step();
      set0(1'b1, 1'b0, 8'h01, 8'h00); step();
      set0(1'b0, 1'b0, 8'h00, 8'h00);
      chk("lit_idle_readback", 32'(rsp0_rdata), 32'(8'h2A));
      step();

      // randomized traffic; unaccepted requests are held unchanged
      for (int k = 0; k < 3000; k++) begin
         if (!(req0_valid && last_g != 0))
            set0(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 7)), 8'($urandom));
         if (!(req1_valid && last_g != 1))
            set1(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 7)), 8'($urandom));
         reset = ($urandom_range(0, 99) == 0);
         step();
      end
      reset = 1'b0;
      set0(1'b0, 1'b0, 8'h00, 8'h00);
      set1(1'b0, 1'b0, 8'h00, 8'h00);
      step(); step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_sram_rr_arbiter
